stepped_enum: RTL and testbench
===============================

# stepped_enum

Parametrised arithmetic-sequence generator implementing the list enumeration `[min, min+step .. max]` for synthesised list producers. It supports any width, signed or unsigned values, ascending and descending steps, and overflow-safe termination. Each element is delivered over a req/ack handshake, and the final element and list exhaustion are flagged explicitly so that downstream fold and map blocks can consume it as a cons/nil stream.

## Interface
- WIDTH, 8, bit width of min, max and value.
- SIGNED, 0, 1 compares min/max/value as two's complement; 0 compares them as unsigned. step is always two's complement.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- ready  input  1  level signal; a rising edge arms a new enumeration, and low aborts it.
- min  input  WIDTH  first element; sampled on the arming edge.
- step  input  WIDTH  signed increment; sampled on the arming edge.
- max  input  WIDTH  inclusive bound; sampled on the arming edge.
- req  input  1  element request; one element is produced per cycle in which it is high.
- ack  output  1  single-cycle response strobe.
- value  output  WIDTH  element; valid while ack=1 and nil=0.
- last  output  1  with ack, marks value as the final element.
- nil  output  1  with ack, marks the list as exhausted; value is invalid.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- Reset state: IDLE. ack=0, value=0, last=0, nil=0. Latched registers and the internal `last_ready` register are 0.
- Arming: at an edge with ready=1 and last_ready=0, from any state:
  - Latch min, step and max, and load cur<=min.
  - Enter RUN if the range is non-empty, otherwise DONE.
- Direction: ascending if step>=0 (signed), descending if step<0.
- The range is empty when:
  - ascending and min>max, or
  - descending and min<max.
  - Comparisons follow SIGNED.
- Element production (RUN, req=1, ready=1): at the next edge the block drives ack=1, value=cur, nil=0 and last=fin, then advances cur.
- Next-value arithmetic: nxt = cur + sign-extended step, computed in WIDTH+2 bits. cur and max are extended per SIGNED, so the intermediate never wraps.
- fin=1 when any of the following holds:
  - ascending, step>0 and nxt>max;
  - descending and nxt<max;
  - nxt falls outside the representable WIDTH range.
- When fin=1 the state becomes DONE, otherwise cur<=nxt[WIDTH-1:0].
- step=0 on a non-empty range is an infinite list: cur is repeated and last is never asserted.
- DONE with req=1, ready=1: the next edge drives ack=1, nil=1, last=0 and holds value. Every further req gets another nil ack.
- IDLE: req is ignored and no ack is produced.
- ready=0 at any edge:
  - state<=IDLE, ack<=0;
  - an in-flight request is dropped and no ack follows;
  - value holds its last value.
- Arming and req in the same cycle: the arm takes effect and req is ignored that cycle (no ack).
- Re-arming while in RUN or DONE discards the old sequence.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- ack latency is 1 cycle: req sampled at edge k gives ack high during cycle k→k+1.
- Throughput: one element per cycle with req held high. ack is high every cycle after the first until ready falls.
- ack is a pulse; it is deasserted the cycle after req drops.
- The arming edge costs one cycle. The first req that can be served is sampled at the edge after the arming edge.
- Asserting reset_n low mid-sequence clears the block immediately, asynchronously. After release it stays in IDLE until a fresh ready rising edge; a ready already high at release counts as a rising edge.

## Test plan
- WIDTH=8, SIGNED=0, min=2, step=3, max=11, req held → values 2, 5, 8, 11 on consecutive acks, last=1 on 11, then nil acks every cycle.
- WIDTH=8, SIGNED=1, min=5, step=-2 (0xFE), max=-3 → 5, 3, 1, -1, -3, last on -3, then nil.
- Overflow: WIDTH=8, SIGNED=0, min=250, step=4, max=255 → 250, 254 (last); no wrap to 2.
- Empty range: min=10, step=1, max=9 → first req acks with nil=1; no value is ever produced. Also step=0, min=4, max=4 → 4 repeated for 20 acks with last=0.
- Handshake and aborts:
  - With gaps in req, each req pulse yields exactly one ack one cycle later.
  - Drop ready mid-list → no further acks.
  - Re-raise ready → the list restarts at min.
  - Arm with req high in the arming cycle → first ack is one cycle later.
- Async reset asserted between clock edges mid-RUN → ack, value, last and nil go to 0 immediately; after release, req without a new ready edge gives no ack.

Source files
------------

// File: rtl/stepped_enum.sv
// Arithmetic-sequence generator for [min, min+step .. max], one element per
// req/ack handshake, with explicit last-element and nil (exhausted) flags.
module stepped_enum #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ready,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] max,
  input  logic             req,
  output logic             ack,
  output logic [WIDTH-1:0] value,
  output logic             last,
  output logic             nil
);

  localparam int XW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_ready;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] r_max;
  logic             r_ack;
  logic [WIDTH-1:0] r_value;
  logic             r_last;
  logic             r_nil;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_cur_nxt;
  logic [WIDTH-1:0] w_step_nxt;
  logic [WIDTH-1:0] w_max_nxt;
  logic             w_ack_nxt;
  logic [WIDTH-1:0] w_value_nxt;
  logic             w_last_nxt;
  logic             w_nil_nxt;

  logic             w_arm;
  logic [XW-1:0]    w_min_in_x;
  logic [XW-1:0]    w_max_in_x;
  logic             w_empty;
  logic [XW-1:0]    w_cur_x;
  logic [XW-1:0]    w_step_x;
  logic [XW-1:0]    w_max_x;
  logic [XW-1:0]    w_nxt;
  logic [2:0]       w_top;
  logic             w_oor;
  logic             w_step_pos;
  logic             w_step_neg;
  logic             w_fin;

  // Extend to WIDTH+2 bits so every later compare can be done as signed.
  function automatic logic [XW-1:0] f_ext(input logic [WIDTH-1:0] x, input logic sgn);
    return sgn ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  endfunction

  assign w_arm      = ready & ~r_last_ready;
  assign w_min_in_x = f_ext(min, SIGNED);
  assign w_max_in_x = f_ext(max, SIGNED);
  assign w_empty    = step[WIDTH-1] ? ($signed(w_min_in_x) < $signed(w_max_in_x))
                                    : ($signed(w_min_in_x) > $signed(w_max_in_x));

  assign w_cur_x    = f_ext(r_cur, SIGNED);
  assign w_step_x   = f_ext(r_step, 1'b1);
  assign w_max_x    = f_ext(r_max, SIGNED);
  assign w_nxt      = w_cur_x + w_step_x;
  assign w_top      = w_nxt[XW-1:WIDTH-1];

  // Signed results fit when the top three bits agree; unsigned when the two guard bits are clear.
  assign w_oor      = SIGNED ? ~((&w_top) | ~(|w_top)) : (|w_nxt[XW-1:WIDTH]);
  assign w_step_neg = r_step[WIDTH-1];
  assign w_step_pos = ~r_step[WIDTH-1] & (|r_step);
  assign w_fin      = (w_step_pos & ($signed(w_nxt) > $signed(w_max_x)))
                    | (w_step_neg & ($signed(w_nxt) < $signed(w_max_x)))
                    | w_oor;

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_step_nxt  = r_step;
    w_max_nxt   = r_max;
    w_ack_nxt   = 1'b0;
    w_value_nxt = r_value;
    w_last_nxt  = 1'b0;
    w_nil_nxt   = 1'b0;
    if (!ready) begin
      w_state_nxt = IDLE;
    end else if (w_arm) begin
      w_step_nxt  = step;
      w_max_nxt   = max;
      w_cur_nxt   = min;
      w_state_nxt = w_empty ? DONE : RUN;
    end else if (req) begin
      case (r_state)
        RUN: begin
          w_ack_nxt   = 1'b1;
          w_value_nxt = r_cur;
          w_last_nxt  = w_fin;
          if (w_fin) begin
            w_state_nxt = DONE;
          end else begin
            w_cur_nxt = w_nxt[WIDTH-1:0];
          end
        end
        DONE: begin
          w_ack_nxt = 1'b1;
          w_nil_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_ready <= 1'b0;
      r_cur        <= '0;
      r_step       <= '0;
      r_max        <= '0;
      r_ack        <= 1'b0;
      r_value      <= '0;
      r_last       <= 1'b0;
      r_nil        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_ready <= ready;
      r_cur        <= w_cur_nxt;
      r_step       <= w_step_nxt;
      r_max        <= w_max_nxt;
      r_ack        <= w_ack_nxt;
      r_value      <= w_value_nxt;
      r_last       <= w_last_nxt;
      r_nil        <= w_nil_nxt;
    end
  end

  assign ack   = r_ack;
  assign value = r_value;
  assign last  = r_last;
  assign nil   = r_nil;

endmodule

// File: tb/tb_stepped_enum.sv
// Scoreboard bench for stepped_enum: an unsigned and a signed instance driven
// by directed and random stimulus, checked against a list-level reference model.
module tb_stepped_enum;

  logic       clk;
  logic       rst_n;
  logic [1:0] ready;
  logic [1:0] req;
  logic [7:0] mn [2];
  logic [7:0] st [2];
  logic [7:0] mx [2];
  logic [1:0] ack;
  logic [1:0] lastf;
  logic [1:0] nilf;
  logic [7:0] val [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic       lst;
    logic       nl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: whole list computed at arm time with integer arithmetic.
  bit         m_lr   [2];
  int         m_mode [2];  // 0 idle, 1 producing, 2 exhausted
  int         m_lst  [2][300];
  int         m_len  [2];
  int         m_idx  [2];
  bit         m_inf  [2];
  logic [7:0] m_val  [2];

  stepped_enum #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u (
    .clock(clk), .reset_n(rst_n), .ready(ready[0]), .min(mn[0]), .step(st[0]),
    .max(mx[0]), .req(req[0]), .ack(ack[0]), .value(val[0]), .last(lastf[0]), .nil(nilf[0])
  );

  stepped_enum #(.WIDTH(8), .SIGNED(1'b1)) u_dut_s (
    .clock(clk), .reset_n(rst_n), .ready(ready[1]), .min(mn[1]), .step(st[1]),
    .max(mx[1]), .req(req[1]), .ack(ack[1]), .value(val[1]), .last(lastf[1]), .nil(nilf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tov(input int d, input logic [7:0] x);
    return (d == 1) ? int'($signed(x)) : int'({24'd0, x});
  endfunction

  task automatic build(input int d);
    int v, lim, s, nv, lo, hi;
    bit empty;
    v   = tov(d, mn[d]);
    lim = tov(d, mx[d]);
    s   = int'($signed(st[d]));
    lo  = (d == 1) ? -128 : 0;
    hi  = (d == 1) ? 127 : 255;
    m_len[d] = 0;
    m_inf[d] = 1'b0;
    empty = (s >= 0) ? (v > lim) : (v < lim);
    if (empty) return;
    if (s == 0) begin
      m_lst[d][0] = v;
      m_len[d]    = 1;
      m_inf[d]    = 1'b1;
      return;
    end
    forever begin
      m_lst[d][m_len[d]] = v;
      m_len[d]++;
      nv = v + s;
      if ((s > 0 && nv > lim) || (s < 0 && nv < lim) || nv < lo || nv > hi) break;
      v = nv;
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic model_edge(input int d);
    exp_t e;
    int   v;
    if (!rst_n) begin
      m_lr[d] = 1'b0; m_mode[d] = 0; m_val[d] = '0;
      return;
    end
    e.cyc = cyc + 1;
    if (!ready[d]) begin
      m_mode[d] = 0;
    end else if (!m_lr[d]) begin
      build(d);
      m_mode[d] = (m_len[d] == 0) ? 2 : 1;
      m_idx[d]  = 0;
    end else if (req[d]) begin
      if (m_mode[d] == 1) begin
        v     = m_inf[d] ? m_lst[d][0] : m_lst[d][m_idx[d]];
        e.val = v[7:0];
        e.lst = !m_inf[d] && (m_idx[d] == m_len[d] - 1);
        e.nl  = 1'b0;
        push(d, e);
        m_val[d] = v[7:0];
        if (e.lst) m_mode[d] = 2;
        else if (!m_inf[d]) m_idx[d]++;
      end else if (m_mode[d] == 2) begin
        e.val = m_val[d];
        e.lst = 1'b0;
        e.nl  = 1'b1;
        push(d, e);
      end
    end
    m_lr[d] = ready[d];
  endtask

  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int d, input logic a, input logic [7:0] v, input logic l, input logic n);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (a) begin
      tests++;
      if (!have) begin
        fails++;
        $display("FAIL spurious_ack dut%0d cyc=%0d got val=%0h last=%0b nil=%0b, expected no ack", d, cyc, v, l, n);
      end else begin
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        if (e.cyc != cyc || e.val != v || e.lst != l || e.nl != n) begin
          fails++;
          $display("FAIL ack_data dut%0d got cyc=%0d val=%0h last=%0b nil=%0b, expected cyc=%0d val=%0h last=%0b nil=%0b",
                   d, cyc, v, l, n, e.cyc, e.val, e.lst, e.nl);
        end
      end
    end else if (have && e.cyc <= cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_ack dut%0d cyc=%0d got ack=0, expected val=%0h last=%0b nil=%0b", d, cyc, e.val, e.lst, e.nl);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    chk(0, ack[0], val[0], lastf[0], nilf[0]);
    chk(1, ack[1], val[1], lastf[1], nilf[1]);
  end

  task automatic check1(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic arm(input int d, input logic [7:0] a, input logic [7:0] s, input logic [7:0] b);
    ready[d] = 1'b0; req[d] = 1'b0;
    tick();
    mn[d] = a; st[d] = s; mx[d] = b;
    ready[d] = 1'b1; req[d] = 1'b1;
    tick();
  endtask

  task automatic run(input int d, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      req[d] = gaps ? 1'($urandom % 2) : 1'b1;
      tick();
    end
    req[d] = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ready = '0; req = '0;
    for (int d = 0; d < 2; d++) begin
      mn[d] = '0; st[d] = '0; mx[d] = '0;
      m_lr[d] = 1'b0; m_mode[d] = 0; m_val[d] = '0; m_len[d] = 0; m_idx[d] = 0; m_inf[d] = 1'b0;
    end
    #12;
    check1("reset_ack", {6'd0, ack}, 8'd0);
    check1("reset_value_u", val[0], 8'd0);
    check1("reset_flags", {4'd0, lastf, nilf}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    arm(0, 8'd2, 8'd3, 8'd11);      run(0, 8, 1'b0);
    arm(1, 8'd5, 8'hFE, 8'hFD);     run(1, 8, 1'b0);
    arm(0, 8'd250, 8'd4, 8'd255);   run(0, 5, 1'b0);
    arm(0, 8'd10, 8'd1, 8'd9);      run(0, 3, 1'b0);
    arm(0, 8'd4, 8'd0, 8'd4);       run(0, 21, 1'b0);
    arm(1, 8'h80, 8'h80, 8'h7F);    run(1, 4, 1'b0);
    arm(0, 8'd2, 8'd3, 8'd11);      run(0, 16, 1'b1);

    arm(0, 8'd2, 8'd3, 8'd11);
    req[0] = 1'b1; tick(); tick();
    ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    ready[0] = 1'b1;
    run(0, 6, 1'b0);

    // Async reset between edges while acks are streaming.
    arm(0, 8'd0, 8'd1, 8'd200);
    req[0] = 1'b1; tick(); tick();
    check1("pre_reset_ack", {7'd0, ack[0]}, 8'd1);
    #2;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    check1("async_ack", {7'd0, ack[0]}, 8'd0);
    check1("async_value", val[0], 8'd0);
    check1("async_last", {7'd0, lastf[0]}, 8'd0);
    check1("async_nil", {7'd0, nilf[0]}, 8'd0);
    ready[0] = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ready[0] = 1'b1;
    run(0, 4, 1'b0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req[0] = 1'b1;
    run(0, 4, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom % 40 == 0) ready[d] = ~ready[d];
        if ($urandom % 3 == 0) begin
          mn[d] = 8'($urandom);
          mx[d] = 8'($urandom);
          st[d] = ($urandom % 2 == 1) ? 8'($urandom_range(0, 8)) - 8'd4 : 8'($urandom);
        end
        req[d] = ($urandom % 4) != 0;
      end
      tick();
    end

    req = '0;
    tick(); tick();
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d/%0d pending acks, expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
